// File: rtl/pix_probe.sv
`default_nettype none
// ============================================================================
// Module   : pix_probe
// Purpose  : Samples the pixel-class codes that fall inside the player
//            hitbox during one raster frame and publishes a single
//            prioritised code (hazard first, then the highest code), held
//            for the whole of the following frame.
// Option   : PIX_PROBE_DEBOUNCE_EN - a hazard code is published only when
//            it was seen in two consecutive frames. Otherwise the best
//            non-hazard code is published.
// Revision : 1.0 - initial release
// ============================================================================
module pix_probe #(
    parameter int         HIT_W       = 16,
    parameter int         HIT_H       = 16,
    parameter logic [3:0] HAZARD_CODE = 4'h5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        hblnk,
    input  logic        vblnk,
    input  logic [3:0]  pix_code,
    input  logic [11:0] player_x,
    input  logic [11:0] player_y,
    output logic [3:0]  current_pix,
    output logic        frame_done
);

    // Hitbox extents minus one. The bounds are computed in 13 bits so that a
    // hitbox near the 12-bit coordinate limit never wraps back to column or
    // row 0.
    localparam logic [12:0] c_hit_w_m1 = 13'(HIT_W - 1);
    localparam logic [12:0] c_hit_h_m1 = 13'(HIT_H - 1);

    typedef enum logic [1:0] {
        ST_WAIT_FRAME = 2'd0,
        ST_SCAN       = 2'd1,
        ST_PUBLISH    = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_vblnk_d;
    logic [11:0] r_lx;
    logic [11:0] r_ly;
    logic [3:0]  r_acc;
    logic [3:0]  r_current_pix;
    logic        r_frame_done;

    logic        w_vs_edge;
    logic [12:0] w_h13;
    logic [12:0] w_v13;
    logic [12:0] w_x_lo;
    logic [12:0] w_x_hi;
    logic [12:0] w_y_lo;
    logic [12:0] w_y_hi;
    logic        w_in_box;
    logic        w_sample;
    logic [3:0]  w_publish_code;

    // Hazard wins outright. Otherwise the larger code wins, so background
    // (0) never displaces anything.
    function automatic logic [3:0] merge_code(input logic [3:0] a, input logic [3:0] b);
        if (a == HAZARD_CODE || b == HAZARD_CODE) begin
            return HAZARD_CODE;
        end else if (b > a) begin
            return b;
        end else begin
            return a;
        end
    endfunction

    assign w_vs_edge = vblnk & ~r_vblnk_d;

    assign w_h13  = {2'b00, hcount};
    assign w_v13  = {2'b00, vcount};
    assign w_x_lo = {1'b0, r_lx};
    assign w_y_lo = {1'b0, r_ly};
    assign w_x_hi = w_x_lo + c_hit_w_m1;
    assign w_y_hi = w_y_lo + c_hit_h_m1;

    assign w_in_box = (w_h13 >= w_x_lo) && (w_h13 <= w_x_hi) &&
                      (w_v13 >= w_y_lo) && (w_v13 <= w_y_hi);

    // Only visible pixels inside the latched hitbox contribute to a frame.
    assign w_sample = (r_state == ST_SCAN) && !hblnk && !vblnk && w_in_box;

`ifdef PIX_PROBE_DEBOUNCE_EN
    logic [3:0] r_acc_nh;
    logic       r_haz_hist;

    // Parallel best-non-hazard accumulator and one-frame hazard history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_nh   <= 4'h0;
            r_haz_hist <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_FRAME: begin
                    if (w_vs_edge) begin
                        r_acc_nh <= 4'h0;
                    end
                end
                ST_SCAN: begin
                    if (w_sample && pix_code != HAZARD_CODE && pix_code > r_acc_nh) begin
                        r_acc_nh <= pix_code;
                    end
                end
                ST_PUBLISH: begin
                    r_acc_nh   <= 4'h0;
                    r_haz_hist <= (r_acc == HAZARD_CODE);
                end
                default: begin
                    r_acc_nh <= 4'h0;
                end
            endcase
        end
    end

    // A lone hazard frame falls back to the best ordinary code.
    assign w_publish_code = (r_acc == HAZARD_CODE && !r_haz_hist) ? r_acc_nh : r_acc;
`else
    assign w_publish_code = r_acc;
`endif

    // Frame state machine: latch position, accumulate, publish once per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_WAIT_FRAME;
            r_vblnk_d     <= 1'b1;
            r_lx          <= 12'h000;
            r_ly          <= 12'h000;
            r_acc         <= 4'h0;
            r_current_pix <= 4'h0;
            r_frame_done  <= 1'b0;
        end else begin
            r_vblnk_d    <= vblnk;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_WAIT_FRAME: begin
                    // The frame in progress at reset is discarded.
                    if (w_vs_edge) begin
                        r_lx    <= player_x;
                        r_ly    <= player_y;
                        r_acc   <= 4'h0;
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_sample) begin
                        r_acc <= merge_code(r_acc, pix_code);
                    end
                    if (w_vs_edge) begin
                        r_state <= ST_PUBLISH;
                    end
                end
                ST_PUBLISH: begin
                    r_current_pix <= w_publish_code;
                    r_frame_done  <= 1'b1;
                    r_lx          <= player_x;
                    r_ly          <= player_y;
                    r_acc         <= 4'h0;
                    r_state       <= ST_SCAN;
                end
                default: begin
                    r_state <= ST_WAIT_FRAME;
                end
            endcase
        end
    end

    assign current_pix = r_current_pix;
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_pix_probe.sv
`default_nettype none
// ============================================================================
// Module   : tb_pix_probe
// Purpose  : Directed frames with hand-computed expected codes for
//            pix_probe. The raster is compressed to the rows and columns
//            around the hitbox of interest, with blanking cycles in between.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pix_probe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount = 11'd0;
    logic [10:0] vcount = 11'd0;
    logic        hblnk = 1'b0;
    logic        vblnk = 1'b0;
    logic [3:0]  pix_code = 4'h0;
    logic [11:0] player_x = 12'd100;
    logic [11:0] player_y = 12'd100;
    logic [3:0]  current_pix;
    logic        frame_done;

    int n_total = 0;
    int n_bad   = 0;
    int pulses  = 0;
    int scene   = 0;
    int spot    = 0;
    int chg_row = -1;
    logic [11:0] chg_x = 12'd0;

`ifdef PIX_PROBE_DEBOUNCE_EN
    localparam int c_exp_f1  = 0;
    localparam int c_exp_f4a = 7;
    localparam int c_exp_f9  = 2;
`else
    localparam int c_exp_f1  = 5;
    localparam int c_exp_f4a = 5;
    localparam int c_exp_f9  = 5;
`endif

    always #5 clk = ~clk;

    pix_probe #(
        .HIT_W       (16),
        .HIT_H       (16),
        .HAZARD_CODE (4'h5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hcount      (hcount),
        .vcount      (vcount),
        .hblnk       (hblnk),
        .vblnk       (vblnk),
        .pix_code    (pix_code),
        .player_x    (player_x),
        .player_y    (player_y),
        .current_pix (current_pix),
        .frame_done  (frame_done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Scene painter: class code at (x,y) for each test scene.
    function automatic logic [3:0] paint(input int sc, input int x, input int y, input int sp);
        logic in_hb;
        in_hb = (x >= 100) && (x <= 115) && (y >= 100) && (y <= 115);
        case (sc)
            1:       return 4'h5;
            2:       return in_hb ? ((x < 108) ? 4'h2 : 4'h3) : 4'h9;
            4:       return (x == sp && y == 115) ? 4'h5 : 4'h7;
            5:       return (x == 639) ? 4'h4 : ((x <= 20) ? 4'h6 : 4'h0);
            7:       return (x < 150) ? 4'h3 : 4'h8;
            9:       return in_hb ? ((x == 105 && y == 105) ? 4'h5 : 4'h2) : 4'h0;
            default: return 4'h0;
        endcase
    endfunction

    // One pixel-clock cycle: sample frame_done, then drive the next inputs.
    task automatic cyc(input int h, input int v, input bit hb, input bit vb, input logic [3:0] code);
        @(negedge clk);
        if (frame_done) pulses++;
        hcount   = 11'(h);
        vcount   = 11'(v);
        hblnk    = hb;
        vblnk    = vb;
        pix_code = code;
    endtask

    // Active rows over up to two column ranges; each row ends with an
    // hblank cycle carrying a bait code inside the hitbox area.
    task automatic run_rows(input int y0, input int y1, input int xa0, input int xa1,
                            input int xb0, input int xb1);
        for (int y = y0; y <= y1; y++) begin
            if (y == chg_row) player_x = chg_x;
            for (int x = xa0; x <= xa1; x++) cyc(x, y, 1'b0, 1'b0, paint(scene, x, y, spot));
            for (int x = xb0; x <= xb1; x++) cyc(x, y, 1'b0, 1'b0, paint(scene, x, y, spot));
            cyc(100, y, 1'b1, 1'b0, 4'hF);
        end
    endtask

    // Vertical blanking with a bait code on a hitbox coordinate.
    task automatic run_vblank();
        for (int i = 0; i < 4; i++) cyc(100, 100, 1'b0, 1'b1, 4'hF);
    endtask

    task automatic run_frame(input int xa0, input int xa1, input int xb0, input int xb1);
        pulses = 0;
        run_rows(90, 130, xa0, xa1, xb0, xb1);
        run_vblank();
    endtask

    initial begin
        // Reset held during the top of a partial frame, released mid-frame.
        scene  = 1;
        pulses = 0;
        run_rows(90, 104, 90, 130, 1, 0);
        check("reset_pix", int'(current_pix), 0);
        check("reset_done", int'(frame_done), 0);
        rst_n = 1'b1;
        run_rows(105, 130, 90, 130, 1, 0);
        run_vblank();
        check("partial_pulses", pulses, 0);
        check("partial_pix", int'(current_pix), 0);

        // F1: hitbox entirely over hazard code.
        run_frame(90, 130, 1, 0);
        check("f1_pix", int'(current_pix), c_exp_f1);
        check("f1_pulses", pulses, 1);

        // F2: codes 2 and 3 in the box, 9 just outside it.
        scene = 2;
        run_frame(90, 130, 1, 0);
        check("f2_pix", int'(current_pix), 3);
        check("f2_pulses", pulses, 1);

        // F3: background only.
        scene = 3;
        run_frame(90, 130, 1, 0);
        check("f3_pix", int'(current_pix), 0);

        // F4a: hazard at the bottom-right corner pixel of the box.
        scene = 4;
        spot  = 115;
        run_frame(90, 130, 1, 0);
        check("f4a_corner", int'(current_pix), c_exp_f4a);

        // F4b: hazard one column past the box. Next position is 630.
        player_x = 12'd630;
        spot     = 116;
        run_frame(90, 130, 1, 0);
        check("f4b_outside", int'(current_pix), 7);
        check("f4b_pulses", pulses, 1);

        // F5: box at 630 is partly off a 640-wide screen.
        player_x = 12'd4090;
        scene    = 5;
        run_frame(0, 20, 620, 639);
        check("f5_right_edge", int'(current_pix), 4);

        // F6: box far off-screen must not wrap onto columns 0..20.
        player_x = 12'd100;
        run_frame(0, 20, 620, 639);
        check("f6_offscreen", int'(current_pix), 0);

        // F7: position moves mid-frame; the old position is still used.
        scene   = 7;
        chg_row = 105;
        chg_x   = 12'd200;
        run_frame(90, 130, 195, 220);
        chg_row = -1;
        check("f7_old_pos", int'(current_pix), 3);

        // F8: the moved position takes effect; the change made now does not.
        player_x = 12'd100;
        run_frame(90, 130, 195, 220);
        check("f8_new_pos", int'(current_pix), 8);
        check("f8_pulses", pulses, 1);

        // F9/F10: single hazard pixel among code 2, two frames in a row.
        scene = 9;
        run_frame(90, 130, 1, 0);
        check("f9_haz_first", int'(current_pix), c_exp_f9);
        run_frame(90, 130, 1, 0);
        check("f10_haz_second", int'(current_pix), 5);

        // Reset asserted mid-frame clears the output at once.
        scene  = 2;
        pulses = 0;
        run_rows(90, 110, 90, 130, 1, 0);
        rst_n = 1'b0;
        #1;
        check("midreset_pix", int'(current_pix), 0);
        check("midreset_done", int'(frame_done), 0);
        run_rows(111, 115, 90, 130, 1, 0);
        rst_n = 1'b1;
        run_rows(116, 130, 90, 130, 1, 0);
        run_vblank();
        check("midreset_partial_pulses", pulses, 0);
        run_frame(90, 130, 1, 0);
        check("after_reset_pix", int'(current_pix), 3);
        check("after_reset_pulses", pulses, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
